// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq_if
//  Description : Request/result bundle between a client and bin2bcd_seq.
//                The client (master) supplies the value to convert and picks
//                the digit to display. The converter (slave) returns the
//                status, the packed BCD result and the selected digit.
//  Revision    : 1.0  initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    localparam int c_sel_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [c_sel_w-1:0]    digit_sel;
    logic [3:0]            digit_out;

    modport master (
        output start, bin_in, digit_sel,
        input  busy, done, bcd_out, digit_out
    );

    modport slave (
        input  start, bin_in, digit_sel,
        output busy, done, bcd_out, digit_out
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3),
//                one input bit per clock. Presents one BCD digit at a time
//                through a digit-select mux for a downstream BCD decoder.
//                Optional macro BIN2BCD_BLANK_EN enables leading-zero
//                blanking on digit_out (bcd_out stays raw).
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    bin2bcd_seq_if.slave   bus
);
    localparam int c_sel_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_cnt_w = $clog2(BIN_W + 1);
    localparam int c_bcd_w = 4 * DIGITS;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIN_W - 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Reject configurations that cannot hold every input value.
    if ((BIN_W < 1) || (BIN_W > 16)) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W=%0d outside 1..16", BIN_W);
    end
    if (pow10(DIGITS) < (64'd1 << BIN_W)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;
    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_scratch;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_scratch_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_done;
    logic [3:0]           w_digit;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: accept a start in IDLE, leave SHIFT after the last bit.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Add 3 to every scratch digit >= 5, then shift the next binary bit in.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
        w_scratch_next = {w_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};
    end

    // Datapath: load on accept, iterate while shifting, publish on the last bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_bin     <= bus.bin_in;
                r_scratch <= '0;
                r_count   <= '0;
            end else if (r_state == SHIFT) begin
                r_bin     <= r_bin << 1;
                r_scratch <= w_scratch_next;
                r_count   <= r_count + c_cnt_w'(1);
                if (w_last) r_bcd <= w_scratch_next;
            end
        end
    end

    // Digit mux; out-of-range selects (and blanked leading zeros) give 4'hF.
    always_comb begin
        w_digit = 4'hF;
`ifdef BIN2BCD_BLANK_EN
        begin
            logic w_nz_seen;
            w_nz_seen = 1'b0;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                w_nz_seen = w_nz_seen | (r_bcd[4*i +: 4] != 4'd0);
                if (bus.digit_sel == c_sel_w'(i))
                    w_digit = (w_nz_seen || (i == 0)) ? r_bcd[4*i +: 4] : 4'hF;
            end
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.digit_sel == c_sel_w'(i)) w_digit = r_bcd[4*i +: 4];
        end
`endif
    end

    assign bus.busy      = (r_state == SHIFT);
    assign bus.done      = r_done;
    assign bus.bcd_out   = r_bcd;
    assign bus.digit_out = w_digit;

endmodule
`default_nettype wire
